topk_argmax: RTL and testbench

- Parametrised successor to the single-index argmax at the classifier output.
- Returns the K largest elements of a DIM-entry signed score vector, sorted descending, as both indices and values.
- Snapshots the input vector on start, so the producing layer may change its output while the scan runs.
- Used for top-K reporting and for confidence margins (top1 − top2).

---
 rtl/topk_argmax.sv | 120 ++++++++++++
 tb/tb_topk_argmax.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/topk_argmax.sv
// Top-K argmax over a snapshotted signed score vector. The scan inserts one
// element per cycle into a sorted list, and the list is published on done.
module topk_argmax #(
  parameter int DATA_WIDTH = 16,
  parameter int DIM        = 10,
  parameter int K          = 3,
  parameter int IDXW       = (DIM <= 1) ? 1 : $clog2(DIM)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic signed [DATA_WIDTH-1:0] vec      [0:DIM-1],
  output logic                         busy,
  output logic                         done,
  output logic        [IDXW-1:0]       topk_idx [0:K-1],
  output logic signed [DATA_WIDTH-1:0] topk_val [0:K-1]
);

  generate
    if (DIM < 1 || K < 1 || K > DIM) begin : g_bad_param
      $fatal(1, "topk_argmax: require DIM >= 1 and 1 <= K <= DIM");
    end
  endgenerate

  localparam logic signed [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [IDXW-1:0] LAST_J = IDXW'(DIM - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

  state_t                      r_state;
  logic signed [DATA_WIDTH-1:0] r_snap [0:DIM-1];
  logic        [IDXW-1:0]       r_j;
  logic        [IDXW-1:0]       r_lidx [0:K-1];
  logic signed [DATA_WIDTH-1:0] r_lval [0:K-1];
  logic        [K-1:0]          r_lvld;

  logic signed [DATA_WIDTH-1:0] w_new_val;
  logic        [K-1:0]          w_ge;
  logic        [IDXW-1:0]       w_nidx [0:K-1];
  logic signed [DATA_WIDTH-1:0] w_nval [0:K-1];
  logic        [K-1:0]          w_nvld;

  // w_ge is a prefix of ones over the sorted valid list; the new element lands
  // in the first slot where it is clear, so ties keep the earlier index first.
  always_comb begin
    w_new_val = r_snap[r_j];
    w_ge      = '0;
    w_nvld    = '0;
    for (int unsigned i = 0; i < K; i++) begin
      w_ge[i]   = r_lvld[i] && (r_lval[i] >= w_new_val);
      w_nidx[i] = r_lidx[i];
      w_nval[i] = r_lval[i];
      w_nvld[i] = r_lvld[i];
    end
    if (!w_ge[0]) begin
      w_nidx[0] = r_j;
      w_nval[0] = w_new_val;
      w_nvld[0] = 1'b1;
    end
    for (int unsigned i = 1; i < K; i++) begin
      if (!w_ge[i]) begin
        if (w_ge[i-1]) begin
          w_nidx[i] = r_j;
          w_nval[i] = w_new_val;
          w_nvld[i] = 1'b1;
        end else begin
          w_nidx[i] = r_lidx[i-1];
          w_nval[i] = r_lval[i-1];
          w_nvld[i] = r_lvld[i-1];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      r_j     <= '0;
      r_lvld  <= '0;
      for (int unsigned i = 0; i < K; i++) begin
        topk_idx[i] <= '0;
        topk_val[i] <= MOST_NEG;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          busy <= start;
          if (start) begin
            for (int unsigned i = 0; i < DIM; i++) r_snap[i] <= vec[i];
            r_lvld  <= '0;
            r_j     <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          for (int unsigned i = 0; i < K; i++) begin
            r_lidx[i] <= w_nidx[i];
            r_lval[i] <= w_nval[i];
          end
          r_lvld <= w_nvld;
          if (r_j == LAST_J) r_state <= S_FINISH;
          else               r_j     <= r_j + IDXW'(1);
        end
        S_FINISH: begin
          for (int unsigned i = 0; i < K; i++) begin
            topk_idx[i] <= r_lidx[i];
            topk_val[i] <= r_lval[i];
          end
          done    <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_topk_argmax.sv
// Scoreboard bench for topk_argmax: main (DIM=10,K=3), DIM=1/K=1 and DIM=10/K=10 instances.
module tb_topk_argmax;
  localparam int DW = 16;
  localparam int MN = -32768;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start_m, start_1, start_t;
  logic signed [DW-1:0] vec_m [0:9];
  logic signed [DW-1:0] vec_1 [0:0];
  logic signed [DW-1:0] vec_t [0:9];
  logic busy_m, done_m, busy_1, done_1, busy_t, done_t;
  logic        [3:0]    idx_m [0:2];
  logic signed [DW-1:0] val_m [0:2];
  logic        [0:0]    idx_1 [0:0];
  logic signed [DW-1:0] val_1 [0:0];
  logic        [3:0]    idx_t [0:9];
  logic signed [DW-1:0] val_t [0:9];

  topk_argmax #(.DATA_WIDTH(DW), .DIM(10), .K(3)) u_main (
    .clk(clk), .reset(reset), .start(start_m), .vec(vec_m),
    .busy(busy_m), .done(done_m), .topk_idx(idx_m), .topk_val(val_m));
  topk_argmax #(.DATA_WIDTH(DW), .DIM(1), .K(1)) u_one (
    .clk(clk), .reset(reset), .start(start_1), .vec(vec_1),
    .busy(busy_1), .done(done_1), .topk_idx(idx_1), .topk_val(val_1));
  topk_argmax #(.DATA_WIDTH(DW), .DIM(10), .K(10)) u_ten (
    .clk(clk), .reset(reset), .start(start_t), .vec(vec_t),
    .busy(busy_t), .done(done_t), .topk_idx(idx_t), .topk_val(val_t));

  int n_total = 0;
  int n_pass  = 0;
  int q_m_idx[$], q_m_val[$], q_1_idx[$], q_1_val[$], q_t_idx[$], q_t_val[$];

  int vA[10] = '{5, -2, 9, 0, 7, 9, -8, 1, 3, 4};
  int vC[10] = '{-1, -5, -3, -1, -7, -2, -9, -4, -6, -8};

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic push_m(input int i0, input int i1, input int i2,
                        input int v0, input int v1, input int v2);
    q_m_idx.push_back(i0); q_m_idx.push_back(i1); q_m_idx.push_back(i2);
    q_m_val.push_back(v0); q_m_val.push_back(v1); q_m_val.push_back(v2);
  endtask

  function automatic logic get_done(input int w);
    return (w == 0) ? done_m : (w == 1) ? done_1 : done_t;
  endfunction

  function automatic logic get_busy(input int w);
    return (w == 0) ? busy_m : (w == 1) ? busy_1 : busy_t;
  endfunction

  // Returns at the negedge following the acceptance edge.
  task automatic pulse(input int w);
    @(negedge clk);
    if (w == 0) start_m = 1'b1; else if (w == 1) start_1 = 1'b1; else start_t = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_m = 1'b0; start_1 = 1'b0; start_t = 1'b0;
  endtask

  task automatic wait_done(input int w, input string tag, output int n, output bit busy_ok);
    n = 0;
    busy_ok = 1'b1;
    while (!get_done(w) && n < 100) begin
      if (!get_busy(w)) busy_ok = 1'b0;
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    if (!get_busy(w)) busy_ok = 1'b0;
    if (n >= 100) chk({tag, "_timeout"}, 1, 0);
  endtask

  // Monitors: compare published results against the queued expectations.
  always @(negedge clk) begin
    if (!reset && done_m) begin
      if (q_m_idx.size() < 3) chk("main_unexpected_done", 1, 0);
      else for (int k = 0; k < 3; k++) begin
        chk($sformatf("main_idx[%0d]", k), int'(idx_m[k]), q_m_idx.pop_front());
        chk($sformatf("main_val[%0d]", k), int'(val_m[k]), q_m_val.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && done_1) begin
      if (q_1_idx.size() < 1) chk("one_unexpected_done", 1, 0);
      else begin
        chk("one_idx[0]", int'(idx_1[0]), q_1_idx.pop_front());
        chk("one_val[0]", int'(val_1[0]), q_1_val.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && done_t) begin
      if (q_t_idx.size() < 10) chk("ten_unexpected_done", 1, 0);
      else for (int k = 0; k < 10; k++) begin
        chk($sformatf("ten_idx[%0d]", k), int'(idx_t[k]), q_t_idx.pop_front());
        chk($sformatf("ten_val[%0d]", k), int'(val_t[k]), q_t_val.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cnt, last, dones, seen;
    bit b;
    reset = 1'b1; start_m = 1'b0; start_1 = 1'b0; start_t = 1'b0;
    for (int i = 0; i < 10; i++) begin vec_m[i] = '0; vec_t[i] = '0; end
    vec_1[0] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;

    // reset state
    chk("rst_busy", int'(busy_m), 0);
    chk("rst_done", int'(done_m), 0);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_idx[%0d]", k), int'(idx_m[k]), 0);
      chk($sformatf("rst_val[%0d]", k), int'(val_m[k]), MN);
    end
    chk("rst_one_val", int'(val_1[0]), MN);
    chk("rst_ten_val9", int'(val_t[9]), MN);

    // T1: basic scan with a tie
    for (int i = 0; i < 10; i++) vec_m[i] = 16'(vA[i]);
    push_m(2, 5, 4, 9, 9, 7);
    pulse(0);
    wait_done(0, "t1", n, b);
    chk("t1_latency", n, 11);
    chk("t1_busy", int'(b), 1);
    @(negedge clk);
    chk("t1_done_single", int'(done_m), 0);
    chk("t1_busy_low", int'(busy_m), 0);

    // T2: all most-negative, plus hold of previous result mid-scan
    for (int i = 0; i < 10; i++) vec_m[i] = 16'(MN);
    push_m(0, 1, 2, MN, MN, MN);
    pulse(0);
    repeat (4) @(negedge clk);
    chk("t2_hold_idx0", int'(idx_m[0]), 2);
    chk("t2_hold_val2", int'(val_m[2]), 7);
    wait_done(0, "t2", n, b);
    chk("t2_latency_rest", n, 7);

    // T3: snapshot isolation, then a second scan holding the old result
    for (int i = 0; i < 10; i++) vec_m[i] = 16'(i + 1);
    push_m(9, 8, 7, 10, 9, 8);
    pulse(0);
    for (int i = 0; i < 10; i++) vec_m[i] = 16'(100);
    wait_done(0, "t3a", n, b);
    for (int i = 0; i < 10; i++) vec_m[i] = 16'(vC[i]);
    push_m(0, 3, 5, -1, -1, -2);
    pulse(0);
    repeat (5) @(negedge clk);
    chk("t3_hold_idx0", int'(idx_m[0]), 9);
    chk("t3_hold_val0", int'(val_m[0]), 10);
    wait_done(0, "t3b", n, b);

    // T4: start held high continuously
    for (int i = 0; i < 10; i++) vec_m[i] = 16'(vA[i]);
    repeat (3) push_m(2, 5, 4, 9, 9, 7);
    @(negedge clk) start_m = 1'b1;
    cnt = 0; last = 0; dones = 0; b = 1'b1;
    while (dones < 3 && cnt < 200) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      if (!busy_m) b = 1'b0;
      if (done_m) begin
        if (dones == 0) chk("t4_first_done", cnt, 12);
        else chk($sformatf("t4_interval%0d", dones), cnt - last, 12);
        last = cnt;
        dones++;
        if (dones == 3) start_m = 1'b0;
      end
    end
    start_m = 1'b0;
    chk("t4_done_count", dones, 3);
    chk("t4_busy_never_low", int'(b), 1);
    @(negedge clk);
    chk("t4_busy_after", int'(busy_m), 0);

    // T5: reset in the middle of RUN
    pulse(0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    chk("t5_busy", int'(busy_m), 0);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("t5_idx[%0d]", k), int'(idx_m[k]), 0);
      chk($sformatf("t5_val[%0d]", k), int'(val_m[k]), MN);
    end
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (done_m) seen++;
    end
    chk("t5_no_done", seen, 0);
    for (int i = 0; i < 10; i++) vec_m[i] = 16'(vC[i]);
    push_m(0, 3, 5, -1, -1, -2);
    pulse(0);
    wait_done(0, "t5", n, b);
    chk("t5_latency", n, 11);

    // T6: DIM=1/K=1 and DIM=10/K=10
    vec_1[0] = -16'sd7;
    q_1_idx.push_back(0); q_1_val.push_back(-7);
    pulse(1);
    wait_done(1, "one_a", n, b);
    chk("one_latency", n, 2);
    vec_1[0] = 16'sd123;
    q_1_idx.push_back(0); q_1_val.push_back(123);
    pulse(1);
    wait_done(1, "one_b", n, b);

    for (int i = 0; i < 10; i++) begin
      vec_t[i] = 16'(9 - i);
      q_t_idx.push_back(i);
      q_t_val.push_back(9 - i);
    end
    pulse(2);
    wait_done(2, "ten", n, b);
    chk("ten_latency", n, 11);

    repeat (3) @(negedge clk);
    chk("main_queue_drained", q_m_idx.size(), 0);
    chk("one_queue_drained", q_1_idx.size(), 0);
    chk("ten_queue_drained", q_t_idx.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
